player_mover: RTL

PLAYER_MOVER -- requirements
Module: player_mover

---
 rtl/player_mover.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/player_mover.sv
// Board-game token mover: steps one player tile-by-tile with a slide (MOVE)
// and a hop (JUMP) animation per tile, paced by the video frame tick.
module player_mover #(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_TILES     = 10,
  parameter int MAX_STEPS     = 6,
  parameter int WRAP          = 0,
  parameter int TILE_SIZE     = 48,
  parameter int PLAYER_OFFSET = 16,
  parameter int BASE_Y        = 124,
  parameter int MOVE_FRAMES   = 24,
  parameter int JUMP_FRAMES   = 16,
  parameter int JUMP_HEIGHT   = 30,
  localparam int unsigned TW  = $clog2(NUM_TILES),
  localparam int unsigned PW  = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
  localparam int unsigned SW  = $clog2(MAX_STEPS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_tick,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [PW-1:0]             cmd_player,
  input  logic [SW-1:0]             cmd_steps,
  output logic [NUM_PLAYERS*TW-1:0] tiles,
  output logic [PW-1:0]             act_player,
  output logic [9:0]                act_x,
  output logic [9:0]                act_y,
  output logic                      busy,
  output logic                      move_done,
  output logic                      goal
);

  localparam int unsigned FMAX = (MOVE_FRAMES > JUMP_FRAMES) ? MOVE_FRAMES : JUMP_FRAMES;
  localparam int unsigned CW   = $clog2(FMAX + 1);
  localparam logic [TW-1:0] LAST_TILE = TW'(NUM_TILES - 1);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_JUMP} state_t;

  state_t                    r_state, w_state_n;
  logic [CW-1:0]             r_cnt, w_cnt_n;
  logic [SW-1:0]             r_rem, w_rem_n;
  logic [PW-1:0]             r_player, w_player_n;
  logic [TW-1:0]             r_from, w_from_n;
  logic [TW-1:0]             r_to, w_to_n;
  logic [NUM_PLAYERS*TW-1:0] r_tiles, w_tiles_n;
  logic                      w_done_n, w_goal_n;
  logic                      r_cmd_ready, r_busy, r_move_done, r_goal;
  logic [9:0]                r_act_x, r_act_y;
  logic [SW-1:0]             w_steps_sat;
  logic [TW-1:0]             w_cmd_tile, w_cur_tile;
  logic                      w_cmd_player_ok, w_cmd_motion;
  int                        w_x_n, w_y_n, w_hop;

  function automatic logic [TW-1:0] tile_get(input logic [NUM_PLAYERS*TW-1:0] v,
                                             input logic [PW-1:0] p);
    tile_get = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (p == PW'(i)) tile_get = v[i*TW +: TW];
  endfunction

  function automatic logic [NUM_PLAYERS*TW-1:0] tile_set(input logic [NUM_PLAYERS*TW-1:0] v,
                                                         input logic [PW-1:0] p,
                                                         input logic [TW-1:0] t);
    tile_set = v;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (p == PW'(i)) tile_set[i*TW +: TW] = t;
  endfunction

  function automatic logic [TW-1:0] tile_next(input logic [TW-1:0] t);
    tile_next = (t == LAST_TILE) ? '0 : t + TW'(1);
  endfunction

  function automatic int tile_x(input logic [TW-1:0] t);
    tile_x = int'(t) * TILE_SIZE + PLAYER_OFFSET;
  endfunction

  // Command qualification: saturate steps, reject no-op or out-of-range requests
  assign w_steps_sat     = (int'(cmd_steps) > MAX_STEPS) ? SW'(MAX_STEPS) : cmd_steps;
  assign w_cmd_player_ok = int'(cmd_player) < NUM_PLAYERS;
  assign w_cmd_tile      = tile_get(r_tiles, cmd_player);
  assign w_cur_tile      = tile_get(r_tiles, r_player);
  assign w_cmd_motion    = w_cmd_player_ok && (w_steps_sat != '0) &&
                           !((WRAP == 0) && (w_cmd_tile == LAST_TILE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_player    <= '0;
      r_from      <= '0;
      r_to        <= '0;
      r_tiles     <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_move_done <= 1'b0;
      r_goal      <= 1'b0;
      r_act_x     <= 10'(PLAYER_OFFSET);
      r_act_y     <= 10'(BASE_Y);
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_rem       <= w_rem_n;
      r_player    <= w_player_n;
      r_from      <= w_from_n;
      r_to        <= w_to_n;
      r_tiles     <= w_tiles_n;
      r_cmd_ready <= (w_state_n == S_IDLE);
      r_busy      <= (w_state_n != S_IDLE);
      r_move_done <= w_done_n;
      r_goal      <= w_goal_n;
      r_act_x     <= 10'(w_x_n);
      r_act_y     <= 10'(w_y_n);
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_rem_n    = r_rem;
    w_player_n = r_player;
    w_from_n   = r_from;
    w_to_n     = r_to;
    w_tiles_n  = r_tiles;
    w_done_n   = 1'b0;
    w_goal_n   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (w_cmd_motion) begin
            w_player_n = cmd_player;
            w_rem_n    = w_steps_sat - SW'(1);
            w_from_n   = w_cmd_tile;
            w_to_n     = tile_next(w_cmd_tile);
            w_cnt_n    = '0;
            w_state_n  = S_MOVE;
          end else begin
            w_done_n = 1'b1;
          end
        end
      end
      S_MOVE: begin
        if (frame_tick) begin
          if (r_cnt == CW'(MOVE_FRAMES - 1)) begin
            w_tiles_n = tile_set(r_tiles, r_player, r_to);
            w_goal_n  = (WRAP == 0) && (r_to == LAST_TILE);
            w_cnt_n   = '0;
            w_state_n = S_JUMP;
          end else begin
            w_cnt_n = r_cnt + CW'(1);
          end
        end
      end
      S_JUMP: begin
        if (frame_tick) begin
          w_cnt_n = r_cnt + CW'(1);
          if (r_cnt == CW'(JUMP_FRAMES - 1)) begin
            w_cnt_n = '0;
            // Leftover steps are dropped once the goal tile is reached
            if ((r_rem != '0) && ((WRAP != 0) || (w_cur_tile != LAST_TILE))) begin
              w_rem_n   = r_rem - SW'(1);
              w_from_n  = w_cur_tile;
              w_to_n    = tile_next(w_cur_tile);
              w_state_n = S_MOVE;
            end else begin
              w_done_n  = 1'b1;
              w_state_n = S_IDLE;
            end
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // Pixel position derived from next-state values so the registered outputs track the FSM
  always_comb begin
    w_hop = 0;
    w_x_n = tile_x(tile_get(w_tiles_n, w_player_n));
    w_y_n = BASE_Y;
    case (w_state_n)
      S_MOVE: begin
        w_x_n = tile_x(w_from_n) +
                ((tile_x(w_to_n) - tile_x(w_from_n)) * int'(w_cnt_n)) / MOVE_FRAMES;
      end
      S_JUMP: begin
        w_hop = (int'(w_cnt_n) < JUMP_FRAMES - int'(w_cnt_n)) ?
                int'(w_cnt_n) : JUMP_FRAMES - int'(w_cnt_n);
        w_y_n = BASE_Y - (JUMP_HEIGHT * w_hop) / (JUMP_FRAMES / 2);
      end
      default: ;
    endcase
  end

  assign cmd_ready  = r_cmd_ready;
  assign tiles      = r_tiles;
  assign act_player = r_player;
  assign act_x      = r_act_x;
  assign act_y      = r_act_y;
  assign busy       = r_busy;
  assign move_done  = r_move_done;
  assign goal       = r_goal;

endmodule
